// File: rtl/sqrt_seq_engine_if.sv
// sqrt_seq_engine_if: request/result bundle between the entry FSM and the sqrt engine
interface sqrt_seq_engine_if #(parameter int NDIG = 6);
    logic                start;
    logic [4*NDIG-1:0]   num_bcd;
    logic [4*NDIG-1:0]   sqrt_bcd;
    logic                busy;
    logic                done;
    logic                err;
    modport master(output start, num_bcd, input sqrt_bcd, busy, done, err);
    modport slave(input start, num_bcd, output sqrt_bcd, busy, done, err);
endinterface

// File: rtl/sqrt_seq_engine.sv
// sqrt_seq_engine: BCD operand -> binary -> scaled restoring root -> BCD, 3 int + 3 frac digits
module sqrt_seq_engine #(
    parameter int NDIG = 6,
    parameter int FRAC = 3,
    parameter int RB   = 20
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    sqrt_seq_engine_if.slave  bus
);
    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(RB + 1);
    localparam logic [2*RB-1:0] SCALE_K = (2*RB)'(10 ** (2 * FRAC));

    typedef enum logic [2:0] {IDLE, CONV, SCALE, ROOT, DABBLE, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   num_q, num_d;
    logic [RB-1:0]   acc_q, acc_d;
    logic            inv_q, inv_d;
    logic [2*RB-1:0] rad_q, rad_d;
    logic [RB+1:0]   rem_q, rem_d;
    logic [RB-1:0]   root_q, root_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]   sqrt_q, sqrt_d;
    logic            err_q, err_d;

    logic [3:0]      digit;
    logic            bad;
    logic [RB+3:0]   sh, rt;
    logic            ok;
    logic [BW-1:0]   adj, bcd_nxt;
    logic            last_conv, last_rb;

    always_comb begin
        digit     = num_q[BW-1 -: 4];
        bad       = digit > 4'd9;
        sh        = {rem_q, rad_q[2*RB-1 -: 2]};
        rt        = {2'b00, root_q, 2'b01};
        ok        = sh >= rt;
        adj       = bcd_q;
        for (int i = 0; i < NDIG; i++)
            adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        bcd_nxt   = {adj[BW-2:0], root_q[RB-1]};
        last_conv = cnt_q == CW'(NDIG - 1);
        last_rb   = cnt_q == CW'(RB - 1);
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        acc_d     = acc_q;
        inv_d     = inv_q;
        rad_d     = rad_q;
        rem_d     = rem_q;
        root_d    = root_q;
        bcd_d     = bcd_q;
        sqrt_d    = sqrt_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (bus.start) begin
                num_d   = bus.num_bcd;
                acc_d   = '0;
                inv_d   = 1'b0;
                rem_d   = '0;
                root_d  = '0;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                acc_d   = acc_q * RB'(10) + RB'(bad ? 4'd0 : digit);
                inv_d   = inv_q | bad;
                num_d   = num_q << 4;
                cnt_d   = last_conv ? '0 : cnt_q + 1'b1;
                state_d = last_conv ? SCALE : CONV;
            end
            SCALE: begin
                rad_d   = (2*RB)'(acc_q) * SCALE_K;
                state_d = ROOT;
            end
            ROOT: begin
                // restoring step: keep the trial remainder only if it did not underflow
                rem_d   = (RB+2)'(ok ? sh - rt : sh);
                root_d  = {root_q[RB-2:0], ok};
                rad_d   = rad_q << 2;
                cnt_d   = last_rb ? '0 : cnt_q + 1'b1;
                state_d = last_rb ? DABBLE : ROOT;
            end
            DABBLE: begin
                bcd_d   = bcd_nxt;
                root_d  = root_q << 1;
                cnt_d   = last_rb ? '0 : cnt_q + 1'b1;
                sqrt_d  = last_rb ? (inv_q ? '0 : bcd_nxt) : sqrt_q;
                err_d   = last_rb ? inv_q : err_q;
                state_d = last_rb ? DONE : DABBLE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            acc_q   <= '0;
            inv_q   <= 1'b0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            bcd_q   <= '0;
            sqrt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            inv_q   <= inv_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            bcd_q   <= bcd_d;
            sqrt_q  <= sqrt_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy     = state_q inside {CONV, SCALE, ROOT, DABBLE};
    assign bus.done     = state_q == DONE;
    assign bus.sqrt_bcd = sqrt_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_sqrt_seq_engine.sv
// tb_sqrt_seq_engine: directed plus random operands checked against an arithmetic sqrt model
module tb_sqrt_seq_engine;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;

    sqrt_seq_engine_if #(.NDIG(6)) bus();

    sqrt_seq_engine dut (.CLOCK_50(clk), .reset(reset_n), .bus(bus.slave));

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [23:0] n, output logic [23:0] r, output logic e);
        longint v = 0;
        longint rad, s;
        logic [3:0] d;
        e = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            d = n[4*i +: 4];
            if (d > 4'd9) begin
                e = 1'b1;
                d = 4'd0;
            end
            v = v * 10 + longint'(d);
        end
        rad = v * 1000000;
        s = longint'($floor($sqrt(real'(rad))));
        while (s * s > rad) s--;
        while ((s + 1) * (s + 1) <= rad) s++;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        if (e) r = '0;
    endfunction

    task automatic run_op(input logic [23:0] n, input logic [23:0] exp_r, input logic exp_e,
                          input int ign_at, input logic [23:0] ign_n);
        int lat = 0;
        int drops = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_bcd = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.num_bcd = 24'($urandom);
        check("busy_rise", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 100 && lat == 0; i++) begin
            if (i == ign_at) begin
                bus.start = 1'b1;
                bus.num_bcd = ign_n;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) lat = i;
            else if (!bus.busy) drops++;
        end
        check("done_latency", 32'(lat), 32'd47);
        check("busy_hold", 32'(drops), 32'd0);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check($sformatf("sqrt_%h", n), 32'(bus.sqrt_bcd), 32'(exp_r));
        check($sformatf("err_%h", n), 32'(bus.err), 32'(exp_e));
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [23:0] n, r;
        logic e;
        int pulses;
        bus.start = 1'b0;
        bus.num_bcd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sqrt", 32'(bus.sqrt_bcd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(24'h000004, 24'h002000, 1'b0, 0, 24'h0);
        run_op(24'h000002, 24'h001414, 1'b0, 0, 24'h0);
        run_op(24'h000010, 24'h003162, 1'b0, 0, 24'h0);
        run_op(24'h999999, 24'h999999, 1'b0, 0, 24'h0);
        run_op(24'h000000, 24'h000000, 1'b0, 0, 24'h0);
        run_op(24'h00001A, 24'h000000, 1'b1, 0, 24'h0);
        run_op(24'h000009, 24'h003000, 1'b0, 0, 24'h0);
        run_op(24'h000004, 24'h002000, 1'b0, 10, 24'h000009);

        // abort mid-operation, then confirm no stray done and a clean restart
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_bcd = 24'h000004;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sqrt", 32'(bus.sqrt_bcd), 32'd0);
        check("abort_err", 32'(bus.err), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_op(24'h000001, 24'h001000, 1'b0, 0, 24'h0);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 6; i++) n[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) n[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
            model(n, r, e);
            run_op(n, r, e, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : 0, 24'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sqrt_seq_engine.md
Name: sqrt_seq_engine

Overview:
- Sequential, fixed-latency square-root engine on the calculator datapath.
- Consumes the 6-digit BCD operand assembled by the top-level keypad/switch entry state machine, on a one-cycle start pulse from the sqrt key.
- Returns the square root as 6 BCD digits in fixed-point format: 3 integer digits, then 3 fractional digits (implied decimal point between digit 3 and digit 2), for the seven-segment drivers.
- Pipeline inside: BCD-to-binary, scale, digit-by-digit binary root, double-dabble binary-to-BCD.

Parameters:
- NDIG, 6, number of BCD digits in operand and result.
- FRAC, 3, fractional result digits. Must equal NDIG/2.
- RB, 20, root width in bits, ceil(log2(10^NDIG)). Radicand width is 2*RB = 40.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- num_bcd  in  24  operand, BCD, digit 5 = bits [23:20] (most significant).
- sqrt_bcd  out  24  result BCD, equal to floor(sqrt(N)*1000); held between operations.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  operand contained a nibble > 9; updated with done.

Behaviour:
- Reset (async, reset=0): state IDLE; sqrt_bcd=0, busy=0, done=0, err=0; all internal accumulators 0.
- IDLE:
  - start=1 at an edge latches num_bcd into an internal register.
  - Sets busy=1 and clears the invalid flag; moves to CONV.
- CONV, NDIG cycles:
  - Digits processed MSD first: acc = acc*10 + digit.
  - Any digit > 9 sets an internal invalid flag; that digit is treated as 0.
- SCALE, 1 cycle: rad = acc * 10^(2*FRAC), 40-bit. No overflow possible (max 999999*10^6 < 2^40).
- ROOT, RB cycles:
  - Restoring digit-by-digit root, consuming 2 radicand bits per cycle, MSB pair first.
  - Remainder trial r' = (rem<<2 | pair) - (root<<2 | 1). If non-negative, keep r' and shift in 1; else keep the shifted remainder and shift in 0.
  - Result is floor(sqrt(rad)), at most 999999.
- DABBLE, RB cycles:
  - Double-dabble: first, add 3 to every BCD nibble >= 5.
  - Then shift left one bit, taking the root MSB.
- DONE (entered on the final DABBLE edge):
  - Registers sqrt_bcd, or 0 if invalid; err = invalid flag; done=1, busy=0.
  - Next edge: done=0, return to IDLE.
- Latency: start accepted at edge k gives done=1 after edge k+NDIG+2*RB+1 (k+47 at defaults), for exactly 1 cycle. Accepting a new start is possible at edge k+48.
- start while busy or in DONE: ignored, with no effect on the in-flight operation.
- num_bcd changes after acceptance: no effect.
- sqrt_bcd and err hold their last values until the next done. They are not cleared at start.
- Reset mid-operation: immediate abort to the reset values; no done pulse is issued.
- Zero operand: valid, result 000000, err=0.
- All arithmetic is unsigned. Widths: acc 20 bits, rad 40 bits, rem 22 bits, root 20 bits, BCD shift register 24 bits.

Test Plan:
- Operand 0x000004, start pulse: busy rises; done at edge k+47; sqrt_bcd=0x002000, err=0.
- Operands 0x000002 and then 0x000010: sqrt_bcd=0x001414, then 0x003162. The second start is issued the cycle after the first done.
- Operand 0x999999: sqrt_bcd=0x999999. Operand 0x000000: sqrt_bcd=0x000000, err=0.
- Operand 0x00001A: err=1 and sqrt_bcd=0x000000 at done, same latency. A following valid 0x000009 gives 0x003000, err=0.
- Start 0x000004, then pulse start with num_bcd=0x000009 at k+10: ignored; the single done gives 0x002000; busy stays high throughout.
- Reset low at k+20 of an operation: busy=0, done never pulses, sqrt_bcd=0. After release, a new start of 0x000001 gives 0x001000.
